// File: rtl/lower_layer_2_1_arbiter_pkg.sv
// Shared types and constants for the lower merge-sort layer arbiter and picker.
package lower_layer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int ELEM_CNT = 3;

  // Index width that stays legal for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lower_layer_2_1_arbiter_if.sv
// Requester-side and sorter-side signal bundle of the lower-layer arbiter.
interface lower_layer_2_1_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  import lower_layer_pkg::*;

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]                     req;
  logic [NUM_REQ*ELEM_CNT*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                     gnt;
  logic [NUM_REQ-1:0]                     ack;
  logic                                   out_valid;
  logic [DATA_WIDTH-1:0]                  out_data;
  logic [ID_W-1:0]                        out_id;
  logic                                   out_last;
  logic                                   err;
  logic                                   sort_load;
  logic [DATA_WIDTH-1:0]                  sort_data_0;
  logic [DATA_WIDTH-1:0]                  sort_data_1;
  logic [DATA_WIDTH-1:0]                  sort_data_2;
  logic                                   sort_update;
  logic                                   sort_done;
  logic [DATA_WIDTH-1:0]                  sort_sorted_data;

  // Arbiter view.
  modport master (
    input  req, req_data, sort_update, sort_done, sort_sorted_data,
    output gnt, ack, out_valid, out_data, out_id, out_last, err,
           sort_load, sort_data_0, sort_data_1, sort_data_2
  );

  // Requesters plus sorter view.
  modport slave (
    output req, req_data, sort_update, sort_done, sort_sorted_data,
    input  gnt, ack, out_valid, out_data, out_id, out_last, err,
           sort_load, sort_data_0, sort_data_1, sort_data_2
  );

endinterface

// File: rtl/lower_layer_2_1_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set req bit above ptr, with wrap.
module lower_layer_rr_pick
  import lower_layer_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [id_width(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]          gnt_oh,
  output logic [id_width(NUM_REQ)-1:0] gnt_idx,
  output logic                        vld
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0] idx_v;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    vld     = 1'b0;
    idx_v   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_v = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!vld && req[idx_v]) begin
        vld            = 1'b1;
        gnt_idx        = idx_v;
        gnt_oh[idx_v]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lower_layer_2_1_arbiter.sv
// Round-robin arbiter/sequencer sharing one 3-input merge-sort unit among NUM_REQ lanes.
// Optional watchdog on RUN enabled by defining LOWER_ARB_WATCHDOG_EN.
module lower_layer_2_1_arbiter
  import lower_layer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64
) (
  input logic                       clk,
  input logic                       rst_n,
  lower_layer_2_1_arbiter_if.master bus
);
  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(ELEM_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ELEM_CNT);

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, win_idx_q, pick_idx;
  logic [NUM_REQ-1:0]    win_oh_q, pick_oh;
  logic                  pick_vld;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic                  fwd, err_d, wd_expire;
  logic [DATA_WIDTH-1:0] op_p0 [ELEM_CNT];
  logic                  out_vld_p1, out_last_p1, err_p1;
  logic [DATA_WIDTH-1:0] out_data_p1;
  logic [ID_W-1:0]       out_id_p1;

  lower_layer_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .vld     (pick_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_vld) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (bus.sort_done || wd_expire) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt       = (state_q == IDLE) ? '0 : win_oh_q;
    bus.ack       = (state_q == RELEASE) ? win_oh_q : '0;
    bus.sort_load = (state_q == LOAD);
  end

  // Updates past ELEM_CNT and sorter strobes outside RUN are dropped and flagged.
  always_comb begin
    fwd     = (state_q == RUN) && bus.sort_update && (cnt_q < CNT_FULL);
    cnt_nxt = cnt_q + CNT_W'(fwd);
    err_d   = 1'b0;
    if (state_q != RUN)
      err_d = bus.sort_update || bus.sort_done;
    else
      err_d = (bus.sort_update && !fwd) ||
              (bus.sort_done && (cnt_nxt < CNT_FULL)) ||
              wd_expire;
  end

`ifdef LOWER_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  wd_q <= '0;
    else if (state_q != RUN || bus.sort_update)  wd_q <= '0;
    else                                         wd_q <= wd_q + WD_W'(1);
  end

  assign wd_expire = (state_q == RUN) && !bus.sort_update &&
                     (wd_q == WD_W'(TIMEOUT - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT > 0);
  assign wd_expire      = 1'b0;
`endif

  // p0: operand capture at grant; p1: forwarded element and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      win_idx_q   <= '0;
      win_oh_q    <= '0;
      cnt_q       <= '0;
      for (int k = 0; k < ELEM_CNT; k++) op_p0[k] <= '0;
      out_vld_p1  <= 1'b0;
      out_last_p1 <= 1'b0;
      out_data_p1 <= '0;
      out_id_p1   <= '0;
      err_p1      <= 1'b0;
    end else begin
      out_vld_p1  <= fwd;
      out_last_p1 <= fwd && (cnt_nxt == CNT_FULL);
      err_p1      <= err_d;
      if (fwd) begin
        out_data_p1 <= bus.sort_sorted_data;
        out_id_p1   <= win_idx_q;
      end
      if (state_q == IDLE && pick_vld) begin
        ptr_q     <= pick_idx;
        win_idx_q <= pick_idx;
        win_oh_q  <= pick_oh;
        for (int k = 0; k < ELEM_CNT; k++)
          op_p0[k] <= bus.req_data[(ELEM_CNT * int'(pick_idx) + k) * DATA_WIDTH +: DATA_WIDTH];
      end
      if (state_q == RELEASE) cnt_q <= '0;
      else                    cnt_q <= cnt_nxt;
    end
  end

  assign bus.sort_data_0 = op_p0[0];
  assign bus.sort_data_1 = op_p0[1];
  assign bus.sort_data_2 = op_p0[2];
  assign bus.out_valid   = out_vld_p1;
  assign bus.out_last    = out_last_p1;
  assign bus.out_data    = out_data_p1;
  assign bus.out_id      = out_id_p1;
  assign bus.err         = err_p1;

endmodule
